// File: rtl/fp_mult_pack_pkg.sv
// Shared FP multiplier definitions: format macros, bias and canonical-qNaN helpers, class encoding.
`ifndef FP_MULT_PACK_DEFS
`define FP_MULT_PACK_DEFS
`define FP32 0
`define FP64 1
`define FP16 2
`define GET_FP_LEN(f)       ((f) == `FP64 ? 64 : ((f) == `FP16 ? 16 : 32))
`define GET_EXP_LEN(f)      ((f) == `FP64 ? 11 : ((f) == `FP16 ? 5 : 8))
`define GET_MANTISSA_LEN(f) ((f) == `FP64 ? 52 : ((f) == `FP16 ? 10 : 23))
`endif

package fp_mult_pack_pkg;

    typedef enum logic [1:0] {
        CLS_NORMAL = 2'd0,
        CLS_ZERO   = 2'd1,
        CLS_INF    = 2'd2,
        CLS_NAN    = 2'd3
    } fp_class_e;

    function automatic int unsigned fp_bias(input int unsigned e);
        return (32'd1 << (e - 32'd1)) - 32'd1;
    endfunction

    // Canonical quiet NaN right-aligned in 64 bits; callers truncate to their format width.
    function automatic logic [63:0] fp_qnan(input int unsigned e, input int unsigned m);
        logic [63:0] q;
        q = ((64'd1 << e) - 64'd1) << m;
        q = q | (64'd1 << (m - 32'd1));
        return q;
    endfunction

endpackage

// File: rtl/fp_round_pack.sv
// Combinational round/pack of a normalized FP value into an IEEE word with exception flags.
// Macro FP_MULT_PACK_RNE_EN selects round-to-nearest-even; otherwise the mantissa is truncated.
module fp_round_pack
    import fp_mult_pack_pkg::*;
#(
    parameter int unsigned E = 8,
    parameter int unsigned M = 23,
    parameter int unsigned L = 1 + E + M,
    localparam int unsigned ES = E + 2
) (
    input  logic                 sign_i,
    input  logic signed [ES-1:0] exp_i,
    input  logic [M-1:0]         man_i,
    input  logic                 guard_i,
    input  logic                 sticky_i,
    input  fp_class_e            cls_i,
    input  logic                 invalid_i,
    output logic [L-1:0]         result_o,
    output logic                 invalid_o,
    output logic                 overflow_o,
    output logic                 underflow_o,
    output logic                 inexact_o
);
    localparam int unsigned MW = M + 1;
    localparam logic signed [ES-1:0] EXP_MAX  = ES'((1 << E) - 1);
    localparam logic signed [ES-1:0] EXP_ZERO = '0;

    logic                 round_up;
    logic [M:0]           man_sum;
    logic signed [ES-1:0] exp_r;
    logic                 lost;

    always_comb begin
`ifdef FP_MULT_PACK_RNE_EN
        round_up = guard_i & (sticky_i | man_i[0]);
`else
        round_up = 1'b0;
`endif
        lost    = guard_i | sticky_i;
        // A carry out of the mantissa leaves the low bits zero, so only the exponent needs bumping.
        man_sum = {1'b0, man_i} + MW'(round_up);
        exp_r   = man_sum[M] ? exp_i + ES'(1) : exp_i;

        result_o    = '0;
        invalid_o   = 1'b0;
        overflow_o  = 1'b0;
        underflow_o = 1'b0;
        inexact_o   = 1'b0;

        case (cls_i)
            CLS_NAN: begin
                result_o  = L'(fp_qnan(E, M));
                invalid_o = invalid_i;
            end
            CLS_INF:  result_o = {sign_i, {E{1'b1}}, {M{1'b0}}};
            CLS_ZERO: result_o = {sign_i, {(L - 1){1'b0}}};
            default: begin
                if (exp_r >= EXP_MAX) begin
                    result_o   = {sign_i, {E{1'b1}}, {M{1'b0}}};
                    overflow_o = 1'b1;
                    inexact_o  = 1'b1;
                end else if (exp_r <= EXP_ZERO) begin
                    result_o    = {sign_i, {(L - 1){1'b0}}};
                    underflow_o = 1'b1;
                    inexact_o   = (|man_i) | lost;
                end else begin
                    result_o  = {sign_i, exp_r[E-1:0], man_sum[M-1:0]};
                    inexact_o = lost;
                end
            end
        endcase
    end

endmodule

// File: rtl/fp_mult_pack.sv
// FP multiplier final stage: exponent combine and normalize (stage 1), round/pack (stage 2).
// Rounding mode set by macro FP_MULT_PACK_RNE_EN inside fp_round_pack (default truncation).
module fp_mult_pack
    import fp_mult_pack_pkg::*;
#(
    parameter int unsigned data_format = `FP32,
    localparam int unsigned L  = `GET_FP_LEN(data_format),
    localparam int unsigned E  = `GET_EXP_LEN(data_format),
    localparam int unsigned M  = `GET_MANTISSA_LEN(data_format),
    localparam int unsigned PW = 2 * (M + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          sign,
    input  logic [E-1:0]  a_exp,
    input  logic [E-1:0]  b_exp,
    input  logic [PW-1:0] product,
    input  logic          a_zero,
    input  logic          b_zero,
    input  logic          a_inf,
    input  logic          b_inf,
    input  logic          a_nan,
    input  logic          b_nan,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [L-1:0]  result,
    output logic          flag_invalid,
    output logic          flag_overflow,
    output logic          flag_underflow,
    output logic          flag_inexact
);
    localparam int unsigned ES   = E + 2;
    localparam int unsigned BIAS = fp_bias(E);

    logic                 s1_valid_q;
    logic                 s1_sign_q;
    logic signed [ES-1:0] s1_exp_d, s1_exp_q;
    logic [M-1:0]         s1_man_d, s1_man_q;
    logic                 s1_guard_d, s1_guard_q;
    logic                 s1_sticky_d, s1_sticky_q;
    fp_class_e            s1_cls_d, s1_cls_q;
    logic                 s1_invalid_d, s1_invalid_q;

    logic                 out_valid_q;
    logic [L-1:0]         result_q;
    logic                 invalid_q, overflow_q, underflow_q, inexact_q;

    logic                 s2_adv;
    logic signed [ES-1:0] exp_sum;
    logic [L-1:0]         rp_result;
    logic                 rp_invalid, rp_overflow, rp_underflow, rp_inexact;

    assign s2_adv   = !out_valid_q || out_ready;
    assign in_ready = !s1_valid_q || s2_adv;

    // Stage 1: exponent combine, leading-one normalization and operand classification.
    always_comb begin
        exp_sum = ES'(a_exp) + ES'(b_exp) - ES'(BIAS);
        if (product[PW-1]) begin
            s1_man_d    = product[PW-2 -: M];
            s1_guard_d  = product[M];
            s1_sticky_d = |product[M-1:0];
            s1_exp_d    = exp_sum + ES'(1);
        end else begin
            s1_man_d    = product[PW-3 -: M];
            s1_guard_d  = product[M-1];
            s1_sticky_d = |product[M-2:0];
            s1_exp_d    = exp_sum;
        end

        s1_invalid_d = (a_inf & b_zero) | (b_inf & a_zero);
        if (a_nan || b_nan || s1_invalid_d) begin
            s1_cls_d = CLS_NAN;
        end else if (a_inf || b_inf) begin
            s1_cls_d = CLS_INF;
        end else if (a_zero || b_zero || (product[PW-1:PW-2] == 2'b00)) begin
            s1_cls_d = CLS_ZERO;
        end else begin
            s1_cls_d = CLS_NORMAL;
        end
    end

    fp_round_pack #(
        .E (E),
        .M (M),
        .L (L)
    ) u_round_pack (
        .sign_i      (s1_sign_q),
        .exp_i       (s1_exp_q),
        .man_i       (s1_man_q),
        .guard_i     (s1_guard_q),
        .sticky_i    (s1_sticky_q),
        .cls_i       (s1_cls_q),
        .invalid_i   (s1_invalid_q),
        .result_o    (rp_result),
        .invalid_o   (rp_invalid),
        .overflow_o  (rp_overflow),
        .underflow_o (rp_underflow),
        .inexact_o   (rp_inexact)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q   <= 1'b0;
            s1_sign_q    <= 1'b0;
            s1_exp_q     <= '0;
            s1_man_q     <= '0;
            s1_guard_q   <= 1'b0;
            s1_sticky_q  <= 1'b0;
            s1_cls_q     <= CLS_NORMAL;
            s1_invalid_q <= 1'b0;
            out_valid_q  <= 1'b0;
            result_q     <= '0;
            invalid_q    <= 1'b0;
            overflow_q   <= 1'b0;
            underflow_q  <= 1'b0;
            inexact_q    <= 1'b0;
        end else begin
            if (in_ready) begin
                s1_valid_q <= in_valid;
            end
            if (in_valid && in_ready) begin
                s1_sign_q    <= sign;
                s1_exp_q     <= s1_exp_d;
                s1_man_q     <= s1_man_d;
                s1_guard_q   <= s1_guard_d;
                s1_sticky_q  <= s1_sticky_d;
                s1_cls_q     <= s1_cls_d;
                s1_invalid_q <= s1_invalid_d;
            end
            if (s2_adv) begin
                out_valid_q <= s1_valid_q;
            end
            // Output word only changes on a real stage-2 load, so it holds through stalls.
            if (s2_adv && s1_valid_q) begin
                result_q    <= rp_result;
                invalid_q   <= rp_invalid;
                overflow_q  <= rp_overflow;
                underflow_q <= rp_underflow;
                inexact_q   <= rp_inexact;
            end
        end
    end

    assign out_valid      = out_valid_q;
    assign result         = result_q;
    assign flag_invalid   = invalid_q;
    assign flag_overflow  = overflow_q;
    assign flag_underflow = underflow_q;
    assign flag_inexact   = inexact_q;

endmodule

// File: tb/tb_fp_mult_pack.sv
// Scoreboard bench for fp_mult_pack (FP32); expected words come from an integer reference model.
module tb_fp_mult_pack;

    typedef struct {
        logic        sign;
        logic [7:0]  ae;
        logic [7:0]  be;
        logic [47:0] prod;
        logic        az, bz, ai, bi, an, bn;
    } op_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] result;
    logic        flag_invalid, flag_overflow, flag_underflow, flag_inexact;
    op_t         cur_op = '{1'b0, 8'd0, 8'd0, 48'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

    logic [35:0] exp_q[$];
    int          n_checks = 0;
    int          n_pass   = 0;
    bit          rand_bp  = 1'b0;

    always #5 clk = ~clk;

    fp_mult_pack dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .sign           (cur_op.sign),
        .a_exp          (cur_op.ae),
        .b_exp          (cur_op.be),
        .product        (cur_op.prod),
        .a_zero         (cur_op.az),
        .b_zero         (cur_op.bz),
        .a_inf          (cur_op.ai),
        .b_inf          (cur_op.bi),
        .a_nan          (cur_op.an),
        .b_nan          (cur_op.bn),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .result         (result),
        .flag_invalid   (flag_invalid),
        .flag_overflow  (flag_overflow),
        .flag_underflow (flag_underflow),
        .flag_inexact   (flag_inexact)
    );

    wire [35:0] obs = {result, flag_invalid, flag_overflow, flag_underflow, flag_inexact};

    task automatic check(input string tag, input logic [35:0] got, input logic [35:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, want);
    endtask

    // Reference: {result[31:0], invalid, overflow, underflow, inexact}
    function automatic logic [35:0] model(input op_t o);
        int              e;
        int              sh;
        longint unsigned p, rem, half, man, man0;
        logic            inv;
        inv = (o.ai & o.bz) | (o.bi & o.az);
        if (o.an || o.bn || inv) return {32'h7FC00000, inv, 3'b000};
        if (o.ai || o.bi) return {o.sign, 8'hFF, 23'd0, 4'b0000};
        if (o.az || o.bz || o.prod[47:46] == 2'b00) return {o.sign, 31'd0, 4'b0000};
        p    = 64'(o.prod);
        e    = int'(o.ae) + int'(o.be) - 127;
        sh   = o.prod[47] ? 24 : 23;
        if (o.prod[47]) e++;
        man  = (p >> sh) & 64'h7FFFFF;
        rem  = p & ((64'd1 << sh) - 64'd1);
        half = 64'd1 << (sh - 1);
        man0 = man;
`ifdef FP_MULT_PACK_RNE_EN
        if (rem > half || (rem == half && man[0])) man++;
        if (man == 64'h800000) begin
            man = 0;
            e++;
        end
`endif
        if (e >= 255) return {o.sign, 8'hFF, 23'd0, 4'b0101};
        if (e <= 0) return {o.sign, 31'd0, 3'b001, (man0 != 0) || (rem != 0)};
        return {o.sign, 8'(e), 23'(man), 3'b000, rem != 0};
    endfunction

    function automatic op_t mk(input logic s, input logic [7:0] ae, input logic [7:0] be,
                               input logic [47:0] prod);
        op_t o;
        o = '{s, ae, be, prod, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        return o;
    endfunction

    // Monitor away from the active edge: push on accept, pop/compare on transfer, hold check on stall.
    always @(negedge clk) begin
        logic [35:0] want;
        if (rst) begin
            exp_q.delete();
        end else begin
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check("spurious_out", 36'(out_valid), 36'd0);
                end else if (out_ready) begin
                    want = exp_q.pop_front();
                    check("result", obs, want);
                end else begin
                    check("hold", obs, exp_q[0]);
                end
            end
            if (in_valid && in_ready) exp_q.push_back(model(cur_op));
        end
    end

    task automatic send(input op_t o);
        bit acc;
        cur_op   = o;
        in_valid = 1'b1;
        acc      = 1'b0;
        for (int i = 0; i < 200 && !acc; i++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!acc) check("accept_timeout", 36'(in_ready), 36'd1);
    endtask

    task automatic wait_drain();
        int i;
        for (i = 0; i < 300 && (exp_q.size() != 0 || out_valid); i++) begin
            @(posedge clk);
            #1;
        end
        if (i == 300) check("drain_timeout", 36'(exp_q.size()), 36'd0);
    endtask

    initial begin
        op_t o;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 36'(out_valid), 36'd0);
        check("rst_result_flags", obs, 36'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("rst_in_ready", 36'(in_ready), 36'd1);

        // 1.5 x 2.0 with latency check
        send(mk(1'b0, 8'd127, 8'd128, 48'h600000000000));
        check("lat_cycle1", 36'(out_valid), 36'd0);
        @(posedge clk);
        #1;
        check("lat_cycle2", 36'(out_valid), 36'd1);
        check("basic_value", obs, {32'h40400000, 4'b0000});
        wait_drain();

        // Directed corners, back to back
        send(mk(1'b0, 8'd254, 8'd254, 48'h400000000000));
        o = mk(1'b0, 8'd10, 8'd0, 48'd0); o.ai = 1'b1; o.bz = 1'b1; send(o);
        o = mk(1'b1, 8'd0, 8'd10, 48'd0); o.az = 1'b1; o.bi = 1'b1; send(o);
        o = mk(1'b1, 8'd255, 8'd3, 48'h400000000000); o.an = 1'b1; send(o);
        o = mk(1'b0, 8'd3, 8'd255, 48'h400000000000); o.bn = 1'b1; send(o);
        send(mk(1'b0, 8'd127, 8'd127, (48'd1 << 46) | (48'd1 << 22)));
        send(mk(1'b0, 8'd127, 8'd127, (48'd1 << 46) | (48'd1 << 23) | (48'd1 << 22)));
        send(mk(1'b0, 8'd127, 8'd127, (48'd1 << 46) | (48'h7FFFFF << 23) | (48'd1 << 22)));
        send(mk(1'b1, 8'd50, 8'd50, 48'h400000000000));
        send(mk(1'b0, 8'd100, 8'd100, 48'h100000000000));
        o = mk(1'b1, 8'd255, 8'd100, 48'h400000000000); o.ai = 1'b1; send(o);
        send(mk(1'b0, 8'd127, 8'd127, 48'h900000000000));
        send(mk(1'b0, 8'd64, 8'd64, 48'h400000000000));
        wait_drain();

        // Backpressure: two accepts fill the pipe, third waits for out_ready
        out_ready = 1'b0;
        send(mk(1'b0, 8'd127, 8'd128, 48'h600000000000));
        send(mk(1'b1, 8'd130, 8'd120, 48'h900000000000));
        check("bp_in_ready_low", 36'(in_ready), 36'd0);
        fork
            send(mk(1'b0, 8'd140, 8'd100, 48'h7FFFFF000001));
            begin
                repeat (3) @(posedge clk);
                #1;
                check("bp_still_low", 36'(in_ready), 36'd0);
                out_ready = 1'b1;
            end
        join
        wait_drain();

        // Random operands with random downstream stalls
        rand_bp = 1'b1;
        fork
            begin
                for (int k = 0; k < 30; k++) begin
                    logic [23:0] ma, mb;
                    ma = {1'b1, 23'($urandom)};
                    mb = {1'b1, 23'($urandom)};
                    o  = mk(1'($urandom), 8'($urandom_range(40, 200)), 8'($urandom_range(40, 200)),
                            48'(ma) * 48'(mb));
                    if ($urandom_range(0, 9) == 0) o.bz = 1'b1;
                    send(o);
                end
                rand_bp = 1'b0;
            end
            begin
                while (rand_bp) begin
                    @(posedge clk);
                    #1;
                    if (rand_bp) out_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        out_ready = 1'b1;
        wait_drain();

        // Reset with both stages full discards in-flight data
        out_ready = 1'b0;
        send(mk(1'b0, 8'd127, 8'd128, 48'h600000000000));
        send(mk(1'b0, 8'd127, 8'd127, 48'h400000000000));
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_out_valid", 36'(out_valid), 36'd0);
        check("midrst_result", obs, 36'd0);
        rst       = 1'b0;
        out_ready = 1'b1;
        check("midrst_in_ready", 36'(in_ready), 36'd1);
        repeat (6) @(posedge clk);
        #1;
        check("midrst_no_stale", 36'(out_valid), 36'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
